// File: rtl/game_pkg.sv
// Shared types and constants for the game timer and display path.
// Holds the countdown state encoding and BCD digit width.
package game_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_COUNT   = 2'd1,
        TMR_EXPIRED = 2'd2
    } tmr_state_t;

    localparam int GAME_TIMER_DEFAULT = 30;
    localparam int DIGIT_W            = 4;

    // Split a 0..99 value into {tens, ones} BCD digits.
    function automatic logic [2*DIGIT_W-1:0] to_bcd(input int value);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = DIGIT_W'(value / 10);
        ones = DIGIT_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Signal bundle between game_fsm, the 1 Hz source and the countdown timer.
// master drives the timing/control inputs, slave is the timer itself.
interface game_countdown_timer_if
    import game_pkg::*;
#(
    parameter int GAME_TIMER = GAME_TIMER_DEFAULT
) ();

    localparam int TW = $clog2(GAME_TIMER + 1);

    logic                incrementClk;
    logic                game_active;
    logic                startGame;
    logic                timer_expired;
    logic [TW-1:0]       time_left;
    logic [DIGIT_W-1:0]  time_tens;
    logic [DIGIT_W-1:0]  time_ones;
    logic                time_warn;

    modport master (
        output incrementClk,
        output game_active,
        output startGame,
        input  timer_expired,
        input  time_left,
        input  time_tens,
        input  time_ones,
        input  time_warn
    );

    modport slave (
        input  incrementClk,
        input  game_active,
        input  startGame,
        output timer_expired,
        output time_left,
        output time_tens,
        output time_ones,
        output time_warn
    );

endinterface

// File: rtl/game_countdown_timer_tick_sync.sv
// Two-flop synchroniser plus rising-edge detect for a slow async strobe.
// Produces a single registered clkIn-cycle pulse per rising edge.
module tick_sync (
    input  logic clkIn,
    input  logic reset,
    input  logic async_in,
    output logic tick_out
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            tick_out <= 1'b0;
        end else begin
            sync1    <= async_in;
            sync2    <= sync1;
            prev     <= sync2;
            tick_out <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer with binary and BCD seconds-remaining outputs.
// Optional low-time warning output built only when TIMER_WARN_EN is defined.
module game_countdown_timer
    import game_pkg::*;
#(
    parameter int GAME_TIMER   = GAME_TIMER_DEFAULT,
    parameter int WARN_SECONDS = 5
) (
    input  logic                  clkIn,
    input  logic                  reset,
    game_countdown_timer_if.slave bus
);

    localparam int TW = $clog2(GAME_TIMER + 1);

    localparam logic [TW-1:0]        RELOAD    = TW'(GAME_TIMER);
    localparam logic [2*DIGIT_W-1:0] RELOAD_BCD = to_bcd(GAME_TIMER);
    localparam logic [DIGIT_W-1:0]   RL_TENS   = RELOAD_BCD[2*DIGIT_W-1:DIGIT_W];
    localparam logic [DIGIT_W-1:0]   RL_ONES   = RELOAD_BCD[DIGIT_W-1:0];

    if (GAME_TIMER < 1 || GAME_TIMER > 99) begin : g_bad_timer
        $error("GAME_TIMER out of range 1..99");
    end
    if (WARN_SECONDS < 0 || WARN_SECONDS > GAME_TIMER) begin : g_bad_warn
        $error("WARN_SECONDS out of range 0..GAME_TIMER");
    end

    tmr_state_t          state;
    tmr_state_t          state_d;
    logic [TW-1:0]       left_q;
    logic [TW-1:0]       left_d;
    logic [DIGIT_W-1:0]  tens_q;
    logic [DIGIT_W-1:0]  tens_d;
    logic [DIGIT_W-1:0]  ones_q;
    logic [DIGIT_W-1:0]  ones_d;
    logic                exp_q;
    logic                exp_d;
    logic                tick;

    tick_sync u_tick_sync (
        .clkIn    (clkIn),
        .reset    (reset),
        .async_in (bus.incrementClk),
        .tick_out (tick)
    );

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state  <= TMR_IDLE;
            left_q <= RELOAD;
            tens_q <= RL_TENS;
            ones_q <= RL_ONES;
            exp_q  <= 1'b0;
        end else begin
            state  <= state_d;
            left_q <= left_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            exp_q  <= exp_d;
        end
    end

    // Abort and re-arm take priority over a coincident tick.
    always_comb begin
        state_d = state;
        left_d  = left_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        exp_d   = exp_q;
        unique case (state)
            TMR_IDLE: begin
                left_d = RELOAD;
                tens_d = RL_TENS;
                ones_d = RL_ONES;
                exp_d  = 1'b0;
                if (bus.game_active) begin
                    state_d = TMR_COUNT;
                end
            end
            TMR_COUNT: begin
                if (!bus.game_active) begin
                    state_d = TMR_IDLE;
                    left_d  = RELOAD;
                    tens_d  = RL_TENS;
                    ones_d  = RL_ONES;
                    exp_d   = 1'b0;
                end else if (tick) begin
                    if (left_q == TW'(1)) begin
                        state_d = TMR_EXPIRED;
                        left_d  = '0;
                        tens_d  = '0;
                        ones_d  = '0;
                        exp_d   = 1'b1;
                    end else begin
                        left_d = left_q - TW'(1);
                        if (ones_q == '0) begin
                            ones_d = DIGIT_W'(9);
                            tens_d = tens_q - DIGIT_W'(1);
                        end else begin
                            ones_d = ones_q - DIGIT_W'(1);
                        end
                    end
                end
            end
            TMR_EXPIRED: begin
                if (bus.startGame) begin
                    state_d = TMR_IDLE;
                    left_d  = RELOAD;
                    tens_d  = RL_TENS;
                    ones_d  = RL_ONES;
                    exp_d   = 1'b0;
                end
            end
            default: begin
                state_d = TMR_IDLE;
                left_d  = RELOAD;
                tens_d  = RL_TENS;
                ones_d  = RL_ONES;
                exp_d   = 1'b0;
            end
        endcase
    end

`ifdef TIMER_WARN_EN
    logic warn_q;
    logic warn_d;

    // Computed from next-state values so it moves with time_left.
    always_comb begin
        warn_d = (state_d == TMR_COUNT)
              && (left_d <= TW'(WARN_SECONDS))
              && (left_d != '0);
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign bus.time_warn = warn_q;
`else
    assign bus.time_warn = 1'b0;
`endif

    assign bus.timer_expired = exp_q;
    assign bus.time_left     = left_q;
    assign bus.time_tens     = tens_q;
    assign bus.time_ones     = ones_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Self-checking bench for game_countdown_timer against a seconds-level model.
// Build with TIMER_WARN_EN to also check the low-time warning.
module tb_game_countdown_timer;

    localparam int G  = 30;
    localparam int W  = 5;
    localparam int TW = $clog2(G + 1);
    localparam int VW = TW + 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    game_countdown_timer_if #(.GAME_TIMER(G)) bus();

    game_countdown_timer #(
        .GAME_TIMER   (G),
        .WARN_SECONDS (W)
    ) dut (
        .clkIn (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: seconds remaining and round phase (0 idle, 1 running, 2 over).
    int m_left;
    int m_phase;

    function automatic void model_reset();
        m_left  = G;
        m_phase = 0;
    endfunction

    // One clkIn edge where a tick, game_active and startGame are seen together.
    function automatic void model_step(input bit t, input bit ga, input bit sg);
        if (m_phase == 0) begin
            if (ga) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!ga) begin
                m_phase = 0;
                m_left  = G;
            end else if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            if (sg) begin
                m_phase = 0;
                m_left  = G;
            end
        end
    endfunction

    // Quiet cycles with game_active held: only start/abort can happen.
    function automatic void model_settle(input bit ga);
        if (m_phase == 0 && ga) m_phase = 1;
        else if (m_phase == 1 && !ga) begin
            m_phase = 0;
            m_left  = G;
        end
    endfunction

    function automatic logic [VW-1:0] expv();
        logic w;
`ifdef TIMER_WARN_EN
        w = (m_phase == 1) && (m_left <= W) && (m_left > 0);
`else
        w = 1'b0;
`endif
        return {TW'(m_left), 4'(m_left / 10), 4'(m_left % 10),
                (m_phase == 2), w};
    endfunction

    function automatic logic [VW-1:0] obsv();
        return {bus.time_left, bus.time_tens, bus.time_ones,
                bus.timer_expired, bus.time_warn};
    endfunction

    // Raise incrementClk (if t) and apply controls on the edge where the tick lands.
    task automatic apply_second(input bit t, input bit ga, input bit sg);
        if (t) bus.incrementClk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.game_active = ga;
        bus.startGame   = sg;
        @(posedge clk);
        #1;
        bus.startGame = 1'b0;
        model_step(t, ga, sg);
    endtask

    task automatic finish_second();
        bus.incrementClk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_settle(bus.game_active);
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.incrementClk = 1'b0;
        bus.game_active  = 1'b0;
        bus.startGame    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (obsv() !== expv()) begin
            miscompares++;
            $display("FAIL reset got %h want %h", obsv(), expv());
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            apply_second(1'b1, 1'b0, 1'b0);
            finish_second();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL idle_tick%0d got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_countdown();
        int prev;
        apply_second(1'b0, 1'b1, 1'b0);
        finish_second();
        prev = G;
        for (int i = 0; i < G; i++) begin
            apply_second(1'b1, 1'b1, 1'b0);
            vectors++;
            if (obsv() !== expv() || int'(bus.time_left) != prev - 1) begin
                miscompares++;
                $display("FAIL count_tick%0d got %h want %h", i, obsv(), expv());
            end
            prev = prev - 1;
            finish_second();
        end
    endtask

    task automatic test_expired_hold();
        for (int i = 0; i < 5; i++) begin
            apply_second(1'b1, 1'b1, 1'b0);
            finish_second();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL hold_tick%0d got %h want %h", i, obsv(), expv());
            end
        end
        apply_second(1'b1, 1'b0, 1'b1);
        vectors++;
        if (obsv() !== expv() || bus.time_left !== TW'(G)) begin
            miscompares++;
            $display("FAIL rearm got %h want %h", obsv(), expv());
        end
        finish_second();
    endtask

    task automatic test_abort();
        apply_second(1'b0, 1'b1, 1'b0);
        finish_second();
        for (int i = 0; i < G - 17; i++) begin
            apply_second(1'b1, 1'b1, 1'b0);
            finish_second();
        end
        vectors++;
        if (obsv() !== expv() || bus.time_left !== TW'(17)) begin
            miscompares++;
            $display("FAIL at17 got %h want %h", obsv(), expv());
        end
        apply_second(1'b1, 1'b0, 1'b0);
        vectors++;
        if (obsv() !== expv()) begin
            miscompares++;
            $display("FAIL abort_tick got %h want %h", obsv(), expv());
        end
        finish_second();
        apply_second(1'b1, 1'b1, 1'b0);
        vectors++;
        if (obsv() !== expv() || bus.time_left !== TW'(G)) begin
            miscompares++;
            $display("FAIL start_tick got %h want %h", obsv(), expv());
        end
        finish_second();
        apply_second(1'b1, 1'b1, 1'b0);
        vectors++;
        if (obsv() !== expv() || bus.time_left !== TW'(G - 1)) begin
            miscompares++;
            $display("FAIL first_dec got %h want %h", obsv(), expv());
        end
        finish_second();
    endtask

    task automatic test_async_reset();
        while (m_left > 8) begin
            apply_second(1'b1, 1'b1, 1'b0);
            finish_second();
        end
        #2;
        rst             = 1'b1;
        bus.game_active = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obsv() !== expv()) begin
            miscompares++;
            $display("FAIL async_reset got %h want %h", obsv(), expv());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (obsv() !== expv()) begin
            miscompares++;
            $display("FAIL post_reset got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_random();
        bit t;
        bit ga;
        bit sg;
        ga = bus.game_active;
        for (int i = 0; i < 80; i++) begin
            t  = ($urandom % 4) != 0;
            if (($urandom % 10) == 0) ga = ~ga;
            sg = ($urandom % 5) == 0;
            apply_second(t, ga, sg);
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL rand_edge%0d got %h want %h", i, obsv(), expv());
            end
            finish_second();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL rand_settle%0d got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_countdown();
        test_expired_hold();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
